// File: rtl/sparse_decoder.sv
// Sparse-vector RLE decoder: credit-limited SRAM prefetch, skip-to-index conversion, output FIFO.
// Optional feature: define SPARSE_DECODER_OVF_CHECK_EN for the sticky index_ovf flag.
module sparse_decoder #(
   parameter int ADDR_W        = 10,
   parameter int SRAM_LAT      = 3,
   parameter int OUT_BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   nnz_count,
   output logic              busy,
   output logic              done,
   output logic              sram_rd_en,
   output logic [ADDR_W-1:0] sram_rd_addr,
   input  logic [31:0]       sram_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              out_last,
   output logic              index_ovf
);
   localparam int INDEX_W = 16;
   localparam int PTR_W   = $clog2(OUT_BUF_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int OCC_W   = CNT_W + 1;
   localparam logic [ADDR_W:0] ONE = 1;

   typedef struct packed { logic [15:0] value; logic [15:0] skip; } sram_data_t;
   typedef struct packed { logic [15:0] value; logic [INDEX_W-1:0] index; } decoder_data_t;
   typedef struct packed { decoder_data_t data; logic last; } fifo_entry_t;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W:0]     nnz_q, issue_k, arr_k, left_q;
   logic [SRAM_LAT:1]   vld_q;
   logic [SRAM_LAT:0]   vld_pipe;
   logic [CNT_W-1:0]    inflight, fifo_cnt;
   logic [OCC_W-1:0]    occ_next;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [INDEX_W-1:0]  idx_acc, idx_new;
   logic                first_q, accept, push, pop, credit, last_issue;
   sram_data_t          rd;
   fifo_entry_t         push_e;
   fifo_entry_t         fifo_mem [OUT_BUF_DEPTH];

   assign accept   = (state_q == IDLE) && start;
   assign out_valid = (fifo_cnt != '0);
   assign pop      = out_valid && out_ready;
   assign vld_pipe = {vld_q, sram_rd_en};
   assign push     = vld_pipe[SRAM_LAT];
   assign rd       = sram_rd_data;

   // Occupancy after this cycle's pop; in-flight reads already own a FIFO slot.
   assign occ_next     = OCC_W'(fifo_cnt) + OCC_W'(inflight) - OCC_W'(pop);
   assign credit       = occ_next < OCC_W'(OUT_BUF_DEPTH);
   assign sram_rd_en   = (state_q == FETCH) && credit;
   assign sram_rd_addr = base_q + issue_k[ADDR_W-1:0];
   assign last_issue   = (issue_k == nnz_q - ONE);

   assign busy     = (state_q == FETCH) || (state_q == DRAIN);
   assign done     = (state_q == DONE);
   assign out_data = out_valid ? fifo_mem[rd_ptr].data : '0;
   assign out_last = out_valid ? fifo_mem[rd_ptr].last : 1'b0;

`ifdef SPARSE_DECODER_OVF_CHECK_EN
   logic [INDEX_W:0] sum_w;
   logic             ovf_q;
   assign sum_w     = {1'b0, idx_acc} + {1'b0, rd.skip} + (INDEX_W+1)'(1);
   assign idx_new   = first_q ? rd.skip : sum_w[INDEX_W-1:0];
   assign index_ovf = ovf_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   ovf_q <= 1'b0;
      else if (accept)                              ovf_q <= 1'b0;
      else if (push && !first_q && sum_w[INDEX_W])  ovf_q <= 1'b1;
   end
`else
   assign idx_new   = first_q ? rd.skip : idx_acc + rd.skip + INDEX_W'(1);
   assign index_ovf = 1'b0;
`endif

   always_comb begin
      push_e            = '0;
      push_e.data.value = rd.value;
      push_e.data.index = idx_new;
      push_e.last       = (arr_k == nnz_q - ONE);
   end

   // A zero-length vector passes through DRAIN so busy is seen for one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = (nnz_count == '0) ? DRAIN : FETCH;
         FETCH: if (sram_rd_en && last_issue) state_d = DRAIN;
         DRAIN: if ((left_q == '0) || ((left_q == ONE) && pop)) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         base_q   <= '0;
         nnz_q    <= '0;
         issue_k  <= '0;
         arr_k    <= '0;
         left_q   <= '0;
         vld_q    <= '0;
         inflight <= '0;
         fifo_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         idx_acc  <= '0;
         first_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         vld_q    <= vld_pipe[SRAM_LAT-1:0];
         inflight <= inflight + CNT_W'(sram_rd_en) - CNT_W'(push);
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
         if (accept) begin
            base_q  <= base_addr;
            nnz_q   <= nnz_count;
            left_q  <= nnz_count;
            issue_k <= '0;
            arr_k   <= '0;
            idx_acc <= '0;
            first_q <= 1'b1;
         end
         if (sram_rd_en) issue_k <= issue_k + ONE;
         if (push) begin
            idx_acc <= idx_new;
            first_q <= 1'b0;
            arr_k   <= arr_k + ONE;
            wr_ptr  <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            left_q <= left_q - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= push_e;
   end
endmodule

// File: tb/tb_sparse_decoder.sv
// Directed bench for sparse_decoder: SRAM model, expected-output scoreboard, occupancy and timing checks.
module tb_sparse_decoder;
   localparam int ADDR_W = 10, LAT = 3, DEPTH = 4;
`ifdef SPARSE_DECODER_OVF_CHECK_EN
   localparam logic EXP_OVF = 1'b1;
`else
   localparam logic EXP_OVF = 1'b0;
`endif

   logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   nnz_count = '0;
   logic busy, done, sram_rd_en, out_valid, out_last, index_ovf;
   logic [ADDR_W-1:0] sram_rd_addr;
   logic [31:0] sram_rd_data, out_data;

   typedef struct packed { logic [31:0] data; logic last; } exp_t;
   exp_t              exp_q[$];
   logic [ADDR_W-1:0] addr_q[$];
   exp_t              mon_e;
   logic [31:0]       mem [0:1023];
   logic [31:0]       sp  [1:LAT];

   int checks = 0, errors = 0, cyc = 0, occ = 0, max_occ = 0;
   int rd_count = 0, hs_count = 0, done_cnt = 0, done_cyc = -1, last_hs = -1;
   int first_rd = -1, first_v = -1, start_cyc = 0;
   logic prev_stall = 0, prev_done = 0, prev_last = 0;
   logic [31:0] prev_data = '0;

   sparse_decoder #(.ADDR_W(ADDR_W), .SRAM_LAT(LAT), .OUT_BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .nnz_count(nnz_count),
      .busy(busy), .done(done), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
      .sram_rd_data(sram_rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .index_ovf(index_ovf));

   always #5 clk = ~clk;

   // SRAM: data appears exactly LAT cycles after the read strobe, garbage otherwise.
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      sp[1] <= sram_rd_en ? mem[sram_rd_addr] : 32'hDEAD_BEEF;
      for (int i = 2; i <= LAT; i++) sp[i] <= sp[i-1];
   end
   assign sram_rd_data = sp[LAT];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 0;
         prev_done  = 0;
      end else begin
         if (sram_rd_en) begin
            rd_count++;
            if (first_rd < 0) first_rd = cyc;
            if (addr_q.size() == 0) chk("extra_rd", 32'(sram_rd_en), 0);
            else chk("rd_addr", 32'(sram_rd_addr), 32'(addr_q.pop_front()));
         end
         if (out_valid && first_v < 0) first_v = cyc;
         if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", out_data, prev_data);
            chk("hold_last", 32'(out_last), 32'(prev_last));
         end
         if (out_valid && out_ready) begin
            hs_count++;
            last_hs = cyc;
            if (exp_q.size() == 0) chk("extra_out", 32'(out_valid), 0);
            else begin
               mon_e = exp_q.pop_front();
               chk("out_data", out_data, mon_e.data);
               chk("out_last", 32'(out_last), 32'(mon_e.last));
            end
         end
         occ = occ + int'(sram_rd_en) - int'(out_valid && out_ready);
         if (occ > max_occ) max_occ = occ;
         chk("occ_le_depth", 32'(occ <= DEPTH), 1);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_1cyc", 32'(prev_done), 0);
         end
         prev_done  = done;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rand(input logic [ADDR_W-1:0] base, input int n);
      for (int k = 0; k < n; k++)
         mem[base + ADDR_W'(k)] = {16'($urandom), 16'($urandom_range(0, 20))};
   endtask

   // Reference model: indices from skips in arrival order, queued as the stimulus is driven.
   task automatic go(input logic [ADDR_W-1:0] base, input int nnz);
      logic [15:0] idx;
      logic [31:0] w;
      logic [ADDR_W-1:0] a;
      exp_t e;
      idx = '0;
      for (int k = 0; k < nnz; k++) begin
         a = base + ADDR_W'(k);
         w = mem[a];
         idx = (k == 0) ? w[15:0] : idx + w[15:0] + 16'd1;
         e.data = {w[31:16], idx};
         e.last = (k == nnz - 1);
         exp_q.push_back(e);
         addr_q.push_back(a);
      end
      rd_count = 0; hs_count = 0; first_rd = -1; first_v = -1; max_occ = 0;
      start_cyc = cyc;
      start = 1; base_addr = base; nnz_count = (ADDR_W+1)'(nnz);
      tick();
      start = 0;
   endtask

   task automatic wait_done(input int maxc);
      int d0, n;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < maxc) begin
         tick();
         n++;
      end
      chk("done_seen", done_cnt - d0, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rd_en", 32'(sram_rd_en), 0);
      chk("rst_rd_addr", 32'(sram_rd_addr), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", 32'(out_last), 0);
      chk("rst_ovf", 32'(index_ovf), 0);
      rst_n = 1;
      tick();

      // 1: basic three-element vector
      mem[10'h010] = {16'h000A, 16'd2};
      mem[10'h011] = {16'h000B, 16'd0};
      mem[10'h012] = {16'h000C, 16'd5};
      go(10'h010, 3);
      wait_done(50);
      chk("t1_sb_empty", exp_q.size(), 0);
      chk("t1_hs", hs_count, 3);
      chk("t1_first_rd", first_rd, start_cyc + 1);
      chk("t1_first_valid", first_v, start_cyc + 2 + LAT);
      chk("t1_done_lat", done_cyc, last_hs + 1);
      chk("t1_ovf", 32'(index_ovf), 0);

      // address wrap and sustained throughput
      fill_rand(10'h3FE, 4);
      go(10'h3FE, 4);
      wait_done(50);
      chk("wrap_sb_empty", exp_q.size(), 0);
      chk("wrap_thru", last_hs - first_v, 3);

      // 2: consumer stalled for 20 cycles
      fill_rand(10'h100, 8);
      out_ready = 0;
      go(10'h100, 8);
      repeat (20) tick();
      chk("t2_stall_rds", rd_count, DEPTH);
      chk("t2_max_occ", max_occ, DEPTH);
      chk("t2_stall_hs", hs_count, 0);
      out_ready = 1;
      wait_done(100);
      chk("t2_hs", hs_count, 8);
      chk("t2_sb_empty", exp_q.size(), 0);
      chk("t2_done_lat", done_cyc, last_hs + 1);

      // 3: empty vector
      go(10'h050, 0);
      chk("t3_busy_c1", 32'(busy), 1);
      chk("t3_done_c1", 32'(done), 0);
      tick();
      chk("t3_busy_c2", 32'(busy), 0);
      chk("t3_done_c2", 32'(done), 1);
      tick();
      chk("t3_done_c3", 32'(done), 0);
      chk("t3_rd_count", rd_count, 0);
      chk("t3_done_cyc", done_cyc, start_cyc + 2);

      // 4: index wrap
      mem[10'h300] = {16'h1111, 16'hFFFE};
      mem[10'h301] = {16'h2222, 16'h0001};
      go(10'h300, 2);
      wait_done(50);
      chk("t4_sb_empty", exp_q.size(), 0);
      chk("t4_ovf", 32'(index_ovf), 32'(EXP_OVF));

      // 5: reset mid-fetch, then a fresh short vector
      fill_rand(10'h320, 6);
      go(10'h320, 6);
      chk("t5_ovf_clr", 32'(index_ovf), 0);
      repeat (3) tick();
      rst_n = 0;
      tick();
      tick();
      exp_q.delete();
      addr_q.delete();
      occ = 0;
      chk("t5_rst_valid", 32'(out_valid), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      rst_n = 1;
      repeat (8) tick();
      chk("t5_idle_valid", 32'(out_valid), 0);
      chk("t5_idle_busy", 32'(busy), 0);
      fill_rand(10'h340, 2);
      go(10'h340, 2);
      wait_done(50);
      chk("t5_hs", hs_count, 2);
      chk("t5_sb_empty", exp_q.size(), 0);

      // 6: second start during FETCH is ignored
      fill_rand(10'h200, 5);
      fill_rand(10'h3A0, 3);
      go(10'h200, 5);
      tick();
      start = 1; base_addr = 10'h3A0; nnz_count = 11'd3;
      tick();
      start = 0;
      wait_done(100);
      chk("t6_hs", hs_count, 5);
      chk("t6_sb_empty", exp_q.size(), 0);
      repeat (5) tick();
      chk("t6_no_restart", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
